// File: rtl/game_sequencer_fsm.sv
// Game-flow controller: sequences start, stage intro/play/clear and win/lose screens.
// Screen strobes are registered from the next-state decode, so they change on the state edge.
module game_sequencer_fsm #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       start_display_done,
  input  logic       stage_1_begin_done,
  input  logic       stage_2_begin_done,
  input  logic       stage_3_begin_done,
  input  logic       stage_1_end_display_done,
  input  logic       stage_2_end_display_done,
  input  logic       stage_3_end_display_done,
  input  logic       WIN_done,
  input  logic       LOSE_done,
  input  logic       stage_clear,
  input  logic       player_dead,
  output logic       wait_start,
  output logic       stage_1_begin,
  output logic       stage_1_done,
  output logic       stage_2_begin,
  output logic       stage_2_done,
  output logic       stage_3_begin,
  output logic       stage_3_done,
  output logic       win,
  output logic       game_over,
  output logic       play_enable,
  output logic [1:0] current_stage
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S1_BEGIN = 4'd1,
    S1_PLAY  = 4'd2,
    S1_DONE  = 4'd3,
    S2_BEGIN = 4'd4,
    S2_PLAY  = 4'd5,
    S2_DONE  = 4'd6,
    S3_BEGIN = 4'd7,
    S3_PLAY  = 4'd8,
    S3_DONE  = 4'd9,
    S_WIN    = 4'd10,
    S_LOSE   = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Output vector layout: {wait_start, s1b, s1d, s2b, s2d, s3b, s3d, win, game_over, play_enable, stage[1:0]}
  localparam logic [11:0] O_START = 12'h800;
  localparam logic [11:0] O_S1B   = 12'h401;
  localparam logic [11:0] O_S1P   = 12'h005;
  localparam logic [11:0] O_S1D   = 12'h201;
  localparam logic [11:0] O_S2B   = 12'h102;
  localparam logic [11:0] O_S2P   = 12'h006;
  localparam logic [11:0] O_S2D   = 12'h082;
  localparam logic [11:0] O_S3B   = 12'h043;
  localparam logic [11:0] O_S3P   = 12'h007;
  localparam logic [11:0] O_S3D   = 12'h023;
  localparam logic [11:0] O_WIN   = 12'h010;
  localparam logic [11:0] O_LOSE  = 12'h008;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             go_q_r;
  logic             done_seen_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [11:0]      out_r;
  logic [11:0]      out_nxt_s;
  logic             go_rise_s;
  logic             cur_done_s;
  logic             hold_state_s;
  logic             hold_run_s;
  logic             hold_expire_s;
  logic             moving_s;

  assign go_rise_s     = go & ~go_q_r;
  assign hold_run_s    = hold_state_s & (done_seen_r | cur_done_s);
  assign hold_expire_s = hold_run_s & (hold_cnt_r == HOLD_LAST);
  assign moving_s      = (state_nxt_s != state_r);

  // Select the done feedback belonging to the current screen; others are ignored.
  always_comb begin
    cur_done_s   = 1'b0;
    hold_state_s = 1'b0;
    case (state_r)
      S_START:  cur_done_s = start_display_done;
      S1_BEGIN: begin cur_done_s = stage_1_begin_done;       hold_state_s = 1'b1; end
      S1_DONE:  begin cur_done_s = stage_1_end_display_done; hold_state_s = 1'b1; end
      S2_BEGIN: begin cur_done_s = stage_2_begin_done;       hold_state_s = 1'b1; end
      S2_DONE:  begin cur_done_s = stage_2_end_display_done; hold_state_s = 1'b1; end
      S3_BEGIN: begin cur_done_s = stage_3_begin_done;       hold_state_s = 1'b1; end
      S3_DONE:  begin cur_done_s = stage_3_end_display_done; hold_state_s = 1'b1; end
      S_WIN:    cur_done_s = WIN_done;
      S_LOSE:   cur_done_s = LOSE_done;
      default: begin
        cur_done_s   = 1'b0;
        hold_state_s = 1'b0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_START:  if (done_seen_r && go_rise_s) state_nxt_s = S1_BEGIN; else state_nxt_s = S_START;
      S1_BEGIN: if (hold_expire_s) state_nxt_s = S1_PLAY; else state_nxt_s = S1_BEGIN;
      S2_BEGIN: if (hold_expire_s) state_nxt_s = S2_PLAY; else state_nxt_s = S2_BEGIN;
      S3_BEGIN: if (hold_expire_s) state_nxt_s = S3_PLAY; else state_nxt_s = S3_BEGIN;
      S1_PLAY: begin
        if (player_dead)      state_nxt_s = S_LOSE;
        else if (stage_clear) state_nxt_s = S1_DONE;
        else                  state_nxt_s = S1_PLAY;
      end
      S2_PLAY: begin
        if (player_dead)      state_nxt_s = S_LOSE;
        else if (stage_clear) state_nxt_s = S2_DONE;
        else                  state_nxt_s = S2_PLAY;
      end
      S3_PLAY: begin
        if (player_dead)      state_nxt_s = S_LOSE;
        else if (stage_clear) state_nxt_s = S3_DONE;
        else                  state_nxt_s = S3_PLAY;
      end
      S1_DONE: if (hold_expire_s) state_nxt_s = S2_BEGIN; else state_nxt_s = S1_DONE;
      S2_DONE: if (hold_expire_s) state_nxt_s = S3_BEGIN; else state_nxt_s = S2_DONE;
      S3_DONE: if (hold_expire_s) state_nxt_s = S_WIN;    else state_nxt_s = S3_DONE;
      S_WIN:   if (done_seen_r && go_rise_s) state_nxt_s = S_START; else state_nxt_s = S_WIN;
      S_LOSE:  if (done_seen_r && go_rise_s) state_nxt_s = S_START; else state_nxt_s = S_LOSE;
      default: state_nxt_s = S_START;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= S_START;
    else         state_r <= state_nxt_s;
  end

  // Go edge detector, sticky done flag and hold counter; flag and counter restart on every transition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      go_q_r      <= 1'b0;
      done_seen_r <= 1'b0;
      hold_cnt_r  <= '0;
    end else begin
      go_q_r <= go;
      if (moving_s) begin
        done_seen_r <= 1'b0;
        hold_cnt_r  <= '0;
      end else begin
        done_seen_r <= done_seen_r | cur_done_s;
        if (hold_run_s) hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        else            hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  // Output decode of the state being entered.
  always_comb begin
    out_nxt_s = O_START;
    case (state_nxt_s)
      S_START:  out_nxt_s = O_START;
      S1_BEGIN: out_nxt_s = O_S1B;
      S1_PLAY:  out_nxt_s = O_S1P;
      S1_DONE:  out_nxt_s = O_S1D;
      S2_BEGIN: out_nxt_s = O_S2B;
      S2_PLAY:  out_nxt_s = O_S2P;
      S2_DONE:  out_nxt_s = O_S2D;
      S3_BEGIN: out_nxt_s = O_S3B;
      S3_PLAY:  out_nxt_s = O_S3P;
      S3_DONE:  out_nxt_s = O_S3D;
      S_WIN:    out_nxt_s = O_WIN;
      S_LOSE:   out_nxt_s = O_LOSE;
      default:  out_nxt_s = O_START;
    endcase
  end

  // Output register, updated on the same edge as the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_r <= O_START;
    else         out_r <= out_nxt_s;
  end

  assign wait_start    = out_r[11];
  assign stage_1_begin = out_r[10];
  assign stage_1_done  = out_r[9];
  assign stage_2_begin = out_r[8];
  assign stage_2_done  = out_r[7];
  assign stage_3_begin = out_r[6];
  assign stage_3_done  = out_r[5];
  assign win           = out_r[4];
  assign game_over     = out_r[3];
  assign play_enable   = out_r[2];
  assign current_stage = out_r[1:0];

endmodule

// File: tb/tb_game_sequencer_fsm.sv
// Directed bench for game_sequencer_fsm with a short hold time (HOLD_CYCLES=4).
module tb_game_sequencer_fsm;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       start_display_done = 1'b0;
  logic       stage_1_begin_done = 1'b0, stage_2_begin_done = 1'b0, stage_3_begin_done = 1'b0;
  logic       stage_1_end_display_done = 1'b0, stage_2_end_display_done = 1'b0;
  logic       stage_3_end_display_done = 1'b0;
  logic       WIN_done = 1'b0, LOSE_done = 1'b0;
  logic       stage_clear = 1'b0, player_dead = 1'b0;
  logic       wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done;
  logic       stage_3_begin, stage_3_done, win, game_over, play_enable;
  logic [1:0] current_stage;

  int n_checks = 0;
  int n_errors = 0;

  // {wait_start, s1b, s1d, s2b, s2d, s3b, s3d, win, game_over, play_enable, stage[1:0]}
  localparam logic [11:0] E_START = 12'h800, E_S1B = 12'h401, E_S1P = 12'h005, E_S1D = 12'h201;
  localparam logic [11:0] E_S2B = 12'h102, E_S2P = 12'h006, E_S2D = 12'h082;
  localparam logic [11:0] E_S3B = 12'h043, E_S3P = 12'h007, E_S3D = 12'h023;
  localparam logic [11:0] E_WIN = 12'h010, E_LOSE = 12'h008;

  logic [11:0] obs;
  assign obs = {wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done,
                stage_3_begin, stage_3_done, win, game_over, play_enable, current_stage};

  game_sequencer_fsm #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .go(go),
    .start_display_done(start_display_done),
    .stage_1_begin_done(stage_1_begin_done), .stage_2_begin_done(stage_2_begin_done),
    .stage_3_begin_done(stage_3_begin_done),
    .stage_1_end_display_done(stage_1_end_display_done),
    .stage_2_end_display_done(stage_2_end_display_done),
    .stage_3_end_display_done(stage_3_end_display_done),
    .WIN_done(WIN_done), .LOSE_done(LOSE_done),
    .stage_clear(stage_clear), .player_dead(player_dead),
    .wait_start(wait_start), .stage_1_begin(stage_1_begin), .stage_1_done(stage_1_done),
    .stage_2_begin(stage_2_begin), .stage_2_done(stage_2_done),
    .stage_3_begin(stage_3_begin), .stage_3_done(stage_3_done),
    .win(win), .game_over(game_over), .play_enable(play_enable),
    .current_stage(current_stage)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_done(input int idx, input logic v);
    case (idx)
      1: stage_1_begin_done = v;
      2: stage_2_begin_done = v;
      3: stage_3_begin_done = v;
      4: stage_1_end_display_done = v;
      5: stage_2_end_display_done = v;
      6: stage_3_end_display_done = v;
      default: ;
    endcase
  endtask

  // Done raised one cycle after entry (pulse or level); advance expected exactly 4 edges later.
  task automatic run_hold(input int idx, input logic [11:0] e_cur, input logic [11:0] e_nxt,
                          input string tag, input bit level);
    check_eq({tag, "_entry"}, 32'(obs), 32'(e_cur));
    tick();
    set_done(idx, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (!level) set_done(idx, 1'b0);
      check_eq({tag, "_hold"}, 32'(obs), 32'(e_cur));
    end
    tick();
    set_done(idx, 1'b0);
    check_eq({tag, "_adv"}, 32'(obs), 32'(e_nxt));
  endtask

  task automatic clear_stage(input logic [11:0] e_play, input logic [11:0] e_done, input string tag);
    check_eq({tag, "_play"}, 32'(obs), 32'(e_play));
    tick();
    check_eq({tag, "_play_stay"}, 32'(obs), 32'(e_play));
    stage_clear = 1'b1;
    tick();
    stage_clear = 1'b0;
    check_eq({tag, "_cleared"}, 32'(obs), 32'(e_done));
  endtask

  task automatic start_game();
    start_display_done = 1'b1;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    start_display_done = 1'b0;
    check_eq("start_to_s1", 32'(obs), 32'(E_S1B));
  endtask

  task automatic to_s2_play();
    start_game();
    run_hold(1, E_S1B, E_S1P, "r_s1b", 1'b0);
    clear_stage(E_S1P, E_S1D, "r_s1");
    run_hold(4, E_S1D, E_S2B, "r_s1d", 1'b0);
    run_hold(2, E_S2B, E_S2P, "r_s2b", 1'b0);
  endtask

  initial begin
    tick();
    tick();
    check_eq("reset_state", 32'(obs), 32'(E_START));
    #2 resetn = 1'b1;
    tick();
    check_eq("after_reset", 32'(obs), 32'(E_START));

    // go without start screen finished is ignored
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    check_eq("go_no_display", 32'(obs), 32'(E_START));

    // Full win path, with spurious inputs in S1_BEGIN and S3_DONE
    start_game();
    stage_2_begin_done = 1'b1;
    stage_clear = 1'b1;
    player_dead = 1'b1;
    tick();
    stage_2_begin_done = 1'b0;
    stage_clear = 1'b0;
    player_dead = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_eq("s1b_spurious", 32'(obs), 32'(E_S1B));
      tick();
    end
    run_hold(1, E_S1B, E_S1P, "s1b_pulse", 1'b0);
    clear_stage(E_S1P, E_S1D, "s1");
    run_hold(4, E_S1D, E_S2B, "s1d_level", 1'b1);
    run_hold(2, E_S2B, E_S2P, "s2b_pulse", 1'b0);
    clear_stage(E_S2P, E_S2D, "s2");
    run_hold(5, E_S2D, E_S3B, "s2d_pulse", 1'b0);
    run_hold(3, E_S3B, E_S3P, "s3b_level", 1'b1);
    clear_stage(E_S3P, E_S3D, "s3");
    stage_clear = 1'b1;
    player_dead = 1'b1;
    tick();
    stage_clear = 1'b0;
    player_dead = 1'b0;
    check_eq("s3d_spurious", 32'(obs), 32'(E_S3D));
    run_hold(6, E_S3D, E_WIN, "s3d_pulse", 1'b0);
    WIN_done = 1'b1;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    WIN_done = 1'b0;
    check_eq("win_restart", 32'(obs), 32'(E_START));

    // Lose priority: both events in the same cycle
    to_s2_play();
    stage_clear = 1'b1;
    player_dead = 1'b1;
    tick();
    stage_clear = 1'b0;
    player_dead = 1'b0;
    check_eq("lose_priority", 32'(obs), 32'(E_LOSE));

    // Restart handshake: go held across LOSE_done must not advance
    go = 1'b1;
    repeat (100) tick();
    check_eq("lose_go_held", 32'(obs), 32'(E_LOSE));
    LOSE_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("lose_done_go_held", 32'(obs), 32'(E_LOSE));
    end
    go = 1'b0;
    tick();
    check_eq("lose_go_fall", 32'(obs), 32'(E_LOSE));
    go = 1'b1;
    tick();
    go = 1'b0;
    LOSE_done = 1'b0;
    check_eq("lose_restart", 32'(obs), 32'(E_START));
    check_eq("lose_restart_stage", 32'(current_stage), 32'd0);

    // Asynchronous reset mid-S2_PLAY, away from any clock edge
    to_s2_play();
    tick();
    check_eq("pre_reset_s2p", 32'(obs), 32'(E_S2P));
    #2 resetn = 1'b0;
    #1;
    check_eq("async_reset", 32'(obs), 32'(E_START));
    tick();
    #2 resetn = 1'b1;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    check_eq("post_reset_go", 32'(obs), 32'(E_START));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer_fsm.md
Name: game_sequencer_fsm

Overview:
Top-level game-flow controller. It drives the mutually exclusive screen-select strobes (wait_start, stage_n_begin, stage_n_done, win, game_over) into the screen-drawing/VGA-mux stage and consumes that stage's *_done feedback. It also gates gameplay through play_enable and current_stage, and it reacts to the gameplay datapath's stage_clear and player_dead events. It sits directly upstream of the screen-drawing mux.

Parameters:
HOLD_CYCLES, 50000000, cycles a finished screen stays displayed before advancing (1 s at 50 MHz); must be >= 1.
CNT_W, 26, hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
go  input  1  start/continue key, level, active-high, synchronous to clk
start_display_done  input  1  start screen fully drawn
stage_1_begin_done, stage_2_begin_done, stage_3_begin_done  input  1 each  stage-n intro screen fully drawn
stage_1_end_display_done, stage_2_end_display_done, stage_3_end_display_done  input  1 each  stage-n clear screen fully drawn
WIN_done, LOSE_done  input  1 each  terminal screen fully drawn
stage_clear  input  1  gameplay reports current stage cleared (single-cycle pulse or level)
player_dead  input  1  gameplay reports player lost
wait_start, stage_1_begin, stage_1_done, stage_2_begin, stage_2_done, stage_3_begin, stage_3_done, win, game_over  output  1 each  screen-select strobes, at most one high
play_enable  output  1  gameplay running
current_stage  output  2  1..3 during stage states, 0 otherwise

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low on resetn.
- Moore FSM. All outputs are decoded from the registered state, so outputs change on the clk edge that updates the state.
- States: S_START, S1_BEGIN, S1_PLAY, S1_DONE, S2_BEGIN, S2_PLAY, S2_DONE, S3_BEGIN, S3_PLAY, S3_DONE, S_WIN, S_LOSE.
- Output decode:
  - S_START -> wait_start=1.
  - Sn_BEGIN -> stage_n_begin=1, current_stage=n.
  - Sn_PLAY -> play_enable=1, current_stage=n.
  - Sn_DONE -> stage_n_done=1, current_stage=n.
  - S_WIN -> win=1.
  - S_LOSE -> game_over=1.
  - All other outputs 0 in each state.
- Reset (resetn=0) forces, asynchronously:
  - state=S_START, so wait_start=1 and every other output is 0 (current_stage=0);
  - hold counter=0, done_seen=0, go_q=0.
- go edge detection: go_q <= go each cycle; go_rise = go & ~go_q. Only go_rise advances the FSM; holding go high never causes a second advance.
- done_seen: a sticky flag, set when the current state's done input is 1. It is cleared on every state transition. Done inputs from other states are ignored.
- Hold counter:
  - Runs only in Sn_BEGIN and Sn_DONE, while done_seen=1 or the done input is 1 this cycle.
  - Increments by 1 per cycle.
  - When it reaches HOLD_CYCLES-1, the state advances on the next edge.
  - It is cleared on every transition.
  - So the done input arriving at cycle t gives a transition at edge t+HOLD_CYCLES.
- Transitions:
  - S_START: done_seen (start_display_done) & go_rise -> S1_BEGIN. go_rise before the display finishes is ignored.
  - Sn_BEGIN: hold expiry -> Sn_PLAY.
  - Sn_PLAY:
    - player_dead -> S_LOSE.
    - else stage_clear -> Sn_DONE.
    - player_dead wins if both are high in the same cycle.
  - Sn_DONE: hold expiry -> S(n+1)_BEGIN for n=1,2; S3_DONE -> S_WIN.
  - S_WIN / S_LOSE: done_seen (WIN_done / LOSE_done) & go_rise -> S_START.
- stage_clear and player_dead are ignored outside Sn_PLAY.
- Illegal state encodings recover to S_START on the next edge.
- Exactly one of the nine screen strobes or play_enable is high in every cycle (one-hot invariant).

Test Plan:
1. Reset and start gating:
   - Assert resetn=0 mid-S2_PLAY -> wait_start=1 and all other outputs 0 immediately, without waiting for a clk edge.
   - Release reset, pulse go without start_display_done -> remains S_START.
2. Full win path with HOLD_CYCLES=4:
   - Stimulus: start_display_done=1; go rise; each begin_done/end_display_done asserted 1 cycle after entry; stage_clear pulsed in each PLAY state.
   - Expected strobe sequence: wait_start -> stage_1_begin (5 cycles) -> play_enable with current_stage=1 -> stage_1_done -> ... -> stage_3_done -> win.
3. Hold timing:
   - stage_1_begin_done pulses for 1 cycle at cycle t in S1_BEGIN -> play_enable rises exactly at edge t+4.
   - done held high continuously -> same timing.
4. Lose priority: in S2_PLAY, stage_clear=1 and player_dead=1 in the same cycle -> next state S_LOSE (game_over=1), never stage_2_done.
5. Restart handshake:
   - In S_LOSE, go held high for 100 cycles, then LOSE_done=1 -> no transition until go falls and rises again.
   - Then -> wait_start=1 and current_stage=0.
6. Spurious inputs:
   - stage_clear or player_dead pulsed during S1_BEGIN or S3_DONE -> no effect.
   - stage_2_begin_done asserted during S1_BEGIN -> hold counter does not start.
